// File: rtl/fir_stream_feeder.sv
// Transmit-side sequencer for the FIR datapath: soft-resets the FIR, loads tap_count coefficients,
// streams the job's samples, drains the pipeline and counts the FIR output beats.
module fir_stream_feeder #(
   parameter  int unsigned MAX_TAPS   = 16,
   parameter  int unsigned SAMP_CNT_W = 16,
   localparam int unsigned TW         = $clog2(MAX_TAPS)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [TW-1:0]         cmd_taps,
   input  logic [SAMP_CNT_W-1:0] cmd_num_samples,
   input  logic                  s_coeff_valid,
   output logic                  s_coeff_ready,
   input  logic [15:0]           s_coeff_data,
   input  logic                  s_samp_valid,
   output logic                  s_samp_ready,
   input  logic [15:0]           s_samp_data,
   output logic                  fir_rstn,
   output logic [TW-1:0]         tap_count,
   output logic                  coeff_data_valid,
   output logic [15:0]           coeff_data,
   output logic                  input_data_valid,
   output logic [15:0]           input_data,
   output logic                  compute,
   input  logic                  fir_out_valid,
   output logic [SAMP_CNT_W-1:0] out_count,
   output logic                  busy,
   output logic                  done,
   output logic                  err_zero_taps
);

   typedef enum logic [2:0] {
      StIdle,
      StFirRst,
      StLoadCoeff,
      StStream,
      StDrain,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic                  phase_q, phase_d;
   logic [TW-1:0]         coeff_cnt_q, coeff_cnt_d;
   logic [SAMP_CNT_W-1:0] samples_left_q, samples_left_d;
   logic [TW-1:0]         tap_count_d;
   logic [SAMP_CNT_W-1:0] out_count_d;

   logic                  cmd_ready_d, s_coeff_ready_d, s_samp_ready_d, fir_rstn_d;
   logic                  coeff_data_valid_d, input_data_valid_d, compute_d;
   logic [15:0]           coeff_data_d, input_data_d;
   logic                  busy_d, done_d, err_zero_taps_d;

   logic cmd_hs, coeff_hs, samp_hs, job_start;

   // Ready outputs are registered, so each handshake is qualified by the flopped ready.
   assign cmd_hs    = cmd_valid & cmd_ready;
   assign coeff_hs  = s_coeff_valid & s_coeff_ready;
   assign samp_hs   = s_samp_valid & s_samp_ready;
   assign job_start = cmd_hs && (cmd_taps != '0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q        <= StIdle;
         phase_q        <= 1'b0;
         coeff_cnt_q    <= '0;
         samples_left_q <= '0;
      end else begin
         state_q        <= state_d;
         phase_q        <= phase_d;
         coeff_cnt_q    <= coeff_cnt_d;
         samples_left_q <= samples_left_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      coeff_cnt_d    = coeff_cnt_q;
      samples_left_d = samples_left_q;
      tap_count_d    = tap_count;
      out_count_d    = out_count;
      unique case (state_q)
         StIdle: begin
            if (job_start) begin
               state_d        = StFirRst;
               phase_d        = 1'b0;
               coeff_cnt_d    = '0;
               tap_count_d    = cmd_taps;
               samples_left_d = cmd_num_samples;
               out_count_d    = '0;
            end
         end
         StFirRst: begin
            phase_d = 1'b1;
            if (phase_q) begin
               state_d = StLoadCoeff;
               phase_d = 1'b0;
            end
         end
         StLoadCoeff: begin
            if (coeff_hs) begin
               coeff_cnt_d = coeff_cnt_q + TW'(1);
               if (coeff_cnt_q == tap_count - TW'(1)) begin
                  state_d = (samples_left_q == '0) ? StDrain : StStream;
               end
            end
         end
         StStream: begin
            if (samp_hs) begin
               samples_left_d = samples_left_q - SAMP_CNT_W'(1);
               if (samples_left_q == SAMP_CNT_W'(1)) state_d = StDrain;
            end
         end
         StDrain: begin
            phase_d = 1'b1;
            if (phase_q) begin
               state_d = StDone;
               phase_d = 1'b0;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (state_q != StIdle && fir_out_valid) out_count_d = out_count + SAMP_CNT_W'(1);
   end

   // Outputs are decoded from the next state so that every registered output lines up with state_q.
   always_comb begin
      cmd_ready_d        = (state_d == StIdle);
      s_coeff_ready_d    = (state_d == StLoadCoeff);
      s_samp_ready_d     = (state_d == StStream) && (samples_left_d != '0);
      fir_rstn_d         = (state_d != StFirRst);
      coeff_data_valid_d = coeff_hs;
      coeff_data_d       = coeff_hs ? s_coeff_data : coeff_data;
      input_data_valid_d = samp_hs;
      input_data_d       = samp_hs ? s_samp_data : input_data;
      compute_d          = (state_d == StStream) || ((state_d == StDrain) && !phase_d);
      busy_d             = (state_d != StIdle);
      done_d             = (state_d == StDone);
      err_zero_taps_d    = (state_q == StIdle) && cmd_hs && (cmd_taps == '0);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cmd_ready        <= 1'b0;
         s_coeff_ready    <= 1'b0;
         s_samp_ready     <= 1'b0;
         fir_rstn         <= 1'b0;
         tap_count        <= '0;
         coeff_data_valid <= 1'b0;
         coeff_data       <= '0;
         input_data_valid <= 1'b0;
         input_data       <= '0;
         compute          <= 1'b0;
         out_count        <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         err_zero_taps    <= 1'b0;
      end else begin
         cmd_ready        <= cmd_ready_d;
         s_coeff_ready    <= s_coeff_ready_d;
         s_samp_ready     <= s_samp_ready_d;
         fir_rstn         <= fir_rstn_d;
         tap_count        <= tap_count_d;
         coeff_data_valid <= coeff_data_valid_d;
         coeff_data       <= coeff_data_d;
         input_data_valid <= input_data_valid_d;
         input_data       <= input_data_d;
         compute          <= compute_d;
         out_count        <= out_count_d;
         busy             <= busy_d;
         done             <= done_d;
         err_zero_taps    <= err_zero_taps_d;
      end
   end

endmodule

// File: tb/tb_fir_stream_feeder.sv
// Randomized scoreboard bench for fir_stream_feeder with a behavioural FIR output-valid stub.
module tb_fir_stream_feeder;
   localparam int TW = 4;
   localparam int SW = 16;

   logic          clk, rstn;
   logic          cmd_valid, cmd_ready;
   logic [TW-1:0] cmd_taps;
   logic [SW-1:0] cmd_num_samples;
   logic          s_coeff_valid, s_coeff_ready;
   logic [15:0]   s_coeff_data;
   logic          s_samp_valid, s_samp_ready;
   logic [15:0]   s_samp_data;
   logic          fir_rstn;
   logic [TW-1:0] tap_count;
   logic          coeff_data_valid, input_data_valid, compute;
   logic [15:0]   coeff_data, input_data;
   logic          fir_out_valid;
   logic [SW-1:0] out_count;
   logic          busy, done, err_zero_taps;

   fir_stream_feeder #(.MAX_TAPS(16), .SAMP_CNT_W(SW)) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_taps(cmd_taps),
      .cmd_num_samples(cmd_num_samples),
      .s_coeff_valid(s_coeff_valid), .s_coeff_ready(s_coeff_ready), .s_coeff_data(s_coeff_data),
      .s_samp_valid(s_samp_valid), .s_samp_ready(s_samp_ready), .s_samp_data(s_samp_data),
      .fir_rstn(fir_rstn), .tap_count(tap_count),
      .coeff_data_valid(coeff_data_valid), .coeff_data(coeff_data),
      .input_data_valid(input_data_valid), .input_data(input_data),
      .compute(compute), .fir_out_valid(fir_out_valid), .out_count(out_count),
      .busy(busy), .done(done), .err_zero_taps(err_zero_taps)
   );

   typedef struct {logic [15:0] data; int cyc;} beat_t;
   typedef struct {int taps; int outs;} job_t;

   beat_t coeff_q[$];
   beat_t samp_q[$];
   job_t  job_q[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int cur_taps = 0;
   int last_taps = 0;
   int fir_seen = 0;
   bit abort = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // FIR stand-in: after a soft reset, each input beat beyond the first cur_taps yields an output.
   initial fir_out_valid = 1'b0;
   always @(posedge clk) begin
      if (!fir_rstn) begin
         fir_seen      <= 0;
         fir_out_valid <= 1'b0;
      end else begin
         fir_out_valid <= input_data_valid && (fir_seen >= cur_taps);
         if (input_data_valid) fir_seen <= fir_seen + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got a beat, expected none", name);
   endtask

   task automatic monitor();
      beat_t b;
      job_t  j;
      bit    prev_done = 0;
      int    rst_low = 0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            prev_done = 0;
            continue;
         end
         if (coeff_data_valid) begin
            if (coeff_q.size() == 0) unexpected("extra_coeff_beat");
            else begin
               b = coeff_q.pop_front();
               check("coeff_data", coeff_data, b.data);
               check("coeff_latency", cyc, b.cyc);
            end
         end
         if (input_data_valid) begin
            check("compute_with_sample", compute, 1);
            if (samp_q.size() == 0) unexpected("extra_sample_beat");
            else begin
               b = samp_q.pop_front();
               check("input_data", input_data, b.data);
               check("input_latency", cyc, b.cyc);
            end
         end
         if (!busy) rst_low = 0;
         else if (!fir_rstn) rst_low++;
         if (prev_done) begin
            check("busy_after_done", busy, 0);
            check("done_width", done, 0);
         end
         if (done) begin
            done_cnt++;
            check("busy_during_done", busy, 1);
            check("fir_rstn_low_cycles", rst_low, 2);
            if (job_q.size() == 0) unexpected("unexpected_done");
            else begin
               j = job_q.pop_front();
               check("out_count", out_count, j.outs);
               check("tap_count", tap_count, j.taps);
            end
         end
         prev_done = done;
      end
   endtask

   task automatic issue_cmd(input int taps, input int n);
      int k = 0;
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid       = 1'b1;
      cmd_taps        = TW'(taps);
      cmd_num_samples = SW'(n);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic run_job(input int taps, input int n, input int gap, input bit rnd,
                          input bit hold, input int abort_after);
      logic [15:0] coeffs[16];
      logic [15:0] samps[64];
      int samp_beats = 0;
      for (int i = 0; i < 16; i++) coeffs[i] = rnd ? 16'($urandom) : 16'(i + 1);
      for (int i = 0; i < 64; i++) samps[i] = rnd ? 16'($urandom) : 16'(i + 1);
      job_q.push_back('{taps, (n > taps) ? n - taps : 0});
      cur_taps = taps;
      abort = 0;
      issue_cmd(taps, n);
      last_taps = taps;
      fork
         begin
            int i = 0;
            while (i < taps && !abort) begin
               @(negedge clk);
               if (abort) break;
               s_coeff_valid = ($urandom_range(99) >= gap);
               s_coeff_data  = coeffs[i];
               if (s_coeff_valid && s_coeff_ready) begin
                  coeff_q.push_back('{coeffs[i], cyc + 1});
                  i++;
               end
            end
            @(negedge clk);
            if (hold && !abort) begin
               s_coeff_valid = 1'b1;
               s_coeff_data  = 16'h7eed;
               repeat (20) @(negedge clk);
            end
            s_coeff_valid = 1'b0;
         end
         begin
            while (samp_beats < n && !abort) begin
               @(negedge clk);
               if (abort) break;
               s_samp_valid = ($urandom_range(99) >= gap);
               s_samp_data  = samps[samp_beats];
               if (s_samp_valid && s_samp_ready) begin
                  samp_q.push_back('{samps[samp_beats], cyc + 1});
                  samp_beats++;
               end
            end
            @(negedge clk);
            s_samp_valid = 1'b0;
         end
         begin
            int k = 0;
            int start = done_cnt;
            while (done_cnt == start && k < 3000) begin
               @(negedge clk);
               k++;
               if (abort_after > 0 && samp_beats >= abort_after) break;
            end
            if (abort_after > 0) begin
               abort = 1;
               rstn  = 1'b0;
               @(negedge clk);
               check("abort_busy", busy, 0);
               check("abort_done", done, 0);
               check("abort_fir_rstn", fir_rstn, 0);
               check("abort_compute", compute, 0);
               check("abort_input_valid", input_data_valid, 0);
               check("abort_coeff_valid", coeff_data_valid, 0);
               check("abort_tap_count", tap_count, 0);
               check("abort_out_count", out_count, 0);
               check("abort_samp_ready", s_samp_ready, 0);
               coeff_q.delete();
               samp_q.delete();
               job_q.delete();
               last_taps = 0;
               @(negedge clk);
               rstn = 1'b1;
               @(negedge clk);
               check("abort_release_fir_rstn", fir_rstn, 1);
            end else if (done_cnt == start) begin
               tests++;
               fails++;
               $display("FAIL job_timeout: got no done, expected done within 3000 cycles");
               abort = 1;
            end
         end
      join
      if (abort_after == 0) begin
         check("coeff_beats_missing", coeff_q.size(), 0);
         check("sample_beats_missing", samp_q.size(), 0);
      end
      abort = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic zero_taps_cmd();
      check("zero_cmd_ready", cmd_ready, 1);
      cmd_valid       = 1'b1;
      cmd_taps        = '0;
      cmd_num_samples = SW'(7);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("err_zero_taps_pulse", err_zero_taps, 1);
      check("zero_busy", busy, 0);
      check("zero_tap_count", tap_count, last_taps);
      @(negedge clk);
      check("err_zero_taps_width", err_zero_taps, 0);
      check("zero_busy_after", busy, 0);
      check("zero_fir_rstn", fir_rstn, 1);
   endtask

   task automatic main_seq();
      rstn = 1'b0;
      cmd_valid = 1'b0; cmd_taps = '0; cmd_num_samples = '0;
      s_coeff_valid = 1'b0; s_coeff_data = '0;
      s_samp_valid = 1'b0; s_samp_data = '0;
      repeat (3) @(negedge clk);
      check("rst_fir_rstn", fir_rstn, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_compute", compute, 0);
      rstn = 1'b1;
      @(negedge clk);
      check("rel_fir_rstn", fir_rstn, 1);
      check("rel_cmd_ready", cmd_ready, 1);
      check("rel_tap_count", tap_count, 0);
      check("rel_out_count", out_count, 0);
      check("rel_valids", {coeff_data_valid, input_data_valid, compute, err_zero_taps}, 0);
      check("rel_readies", {s_coeff_ready, s_samp_ready}, 0);

      run_job(4, 10, 0, 0, 0, 0);
      zero_taps_cmd();
      run_job(4, 10, 40, 0, 1, 0);
      run_job(3, 0, 30, 1, 0, 0);
      repeat (4) run_job($urandom_range(1, 15), $urandom_range(0, 40), 30, 1, 0, 0);
      zero_taps_cmd();
      run_job(4, 10, 20, 1, 0, 4);
      run_job(5, 12, 20, 1, 1, 0);
   endtask

   initial begin
      fork
         monitor();
         main_seq();
      join_any
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
